// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 32-bit integer ALU with a multi-cycle radix-2 divider.
//
// Codes 0..13 (add/sub/logic/shift/compare/multiply) are purely combinational.
// Codes 14..17 (DIV/DIVU/REM/REMU) run on a restoring divider that produces
// one quotient bit per cycle. While it works, stall_cpu_o holds the pipeline
// so the operands stay put. Unused codes return zero.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        synchronous reset, ACTIVE HIGH despite the name
//   alu_control_i  operation select
//   src_a_i        operand A (dividend for divide/remainder)
//   src_b_i        operand B (divisor for divide/remainder)
//   result_o       operation result
//   zero_o         1 when result_o == 0
//   stall_cpu_o    1 while a divide/remainder op is in progress
// -----------------------------------------------------------------------------
module alu #(
  parameter int ALU_CONTROL_WIDTH = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_i,
  input  logic [31:0]                  src_a_i,
  input  logic [31:0]                  src_b_i,
  output logic [31:0]                  result_o,
  output logic                         zero_o,
  output logic                         stall_cpu_o
);

  typedef logic [ALU_CONTROL_WIDTH-1:0] op_t;

  localparam op_t OP_ADD    = op_t'(0);
  localparam op_t OP_SUB    = op_t'(1);
  localparam op_t OP_AND    = op_t'(2);
  localparam op_t OP_OR     = op_t'(3);
  localparam op_t OP_XOR    = op_t'(4);
  localparam op_t OP_SLL    = op_t'(5);
  localparam op_t OP_SRL    = op_t'(6);
  localparam op_t OP_SRA    = op_t'(7);
  localparam op_t OP_SLT    = op_t'(8);
  localparam op_t OP_SLTU   = op_t'(9);
  localparam op_t OP_MUL    = op_t'(10);
  localparam op_t OP_MULH   = op_t'(11);
  localparam op_t OP_MULHSU = op_t'(12);
  localparam op_t OP_MULHU  = op_t'(13);
  localparam op_t OP_DIV    = op_t'(14);
  localparam op_t OP_DIVU   = op_t'(15);
  localparam op_t OP_REM    = op_t'(16);
  localparam op_t OP_REMU   = op_t'(17);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // High half of a 64-bit product. Callers sign- or zero-extend the operands
  // to 64 bits first, so one unsigned multiply serves MULH, MULHSU and MULHU.
  function automatic logic [31:0] mul_hi(input logic [63:0] x, input logic [63:0] y);
    mul_hi = 32'((x * y) >> 32);
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational operations
  // ---------------------------------------------------------------------------
  logic [31:0] comb_result;
  logic [4:0]  shamt;

  assign shamt = src_b_i[4:0];

  // NOTE: every output of an always_comb block gets a default before the case,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    comb_result = 32'd0;
    case (alu_control_i)
      OP_ADD:    comb_result = src_a_i + src_b_i;
      OP_SUB:    comb_result = src_a_i - src_b_i;
      OP_AND:    comb_result = src_a_i & src_b_i;
      OP_OR:     comb_result = src_a_i | src_b_i;
      OP_XOR:    comb_result = src_a_i ^ src_b_i;
      OP_SLL:    comb_result = src_a_i << shamt;
      OP_SRL:    comb_result = src_a_i >> shamt;
      OP_SRA:    comb_result = $signed(src_a_i) >>> shamt;
      OP_SLT:    comb_result = {31'd0, $signed(src_a_i) < $signed(src_b_i)};
      OP_SLTU:   comb_result = {31'd0, src_a_i < src_b_i};
      OP_MUL:    comb_result = src_a_i * src_b_i;
      OP_MULH:   comb_result = mul_hi({{32{src_a_i[31]}}, src_a_i}, {{32{src_b_i[31]}}, src_b_i});
      OP_MULHSU: comb_result = mul_hi({{32{src_a_i[31]}}, src_a_i}, {32'd0, src_b_i});
      OP_MULHU:  comb_result = mul_hi({32'd0, src_a_i}, {32'd0, src_b_i});
      default:   comb_result = 32'd0;  // divide codes and unused codes
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential divider
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;

  logic        is_div_op;
  logic        in_signed;
  logic [31:0] a_mag_in;

  assign is_div_op = (alu_control_i == OP_DIV) || (alu_control_i == OP_DIVU) ||
                     (alu_control_i == OP_REM) || (alu_control_i == OP_REMU);
  assign in_signed = (alu_control_i == OP_DIV) || (alu_control_i == OP_REM);
  // Negating 0x80000000 gives 0x80000000, which is the correct unsigned
  // magnitude 2^31, so the most negative dividend needs no special case.
  assign a_mag_in  = (in_signed && src_a_i[31]) ? -src_a_i : src_a_i;

  logic        op_signed;
  logic        op_is_rem;
  logic [31:0] div_mag;
  logic [32:0] trial;
  logic        trial_ge;

  assign op_signed = (op_q == OP_DIV) || (op_q == OP_REM);
  assign op_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  assign div_mag   = (op_signed && b_q[31]) ? -b_q : b_q;

  // Restoring step: shift the next dividend bit (quotient register MSB) into
  // the partial remainder and subtract the divisor when it fits. The dividend
  // bits leave quot_q from the top as the quotient bits enter at the bottom.
  assign trial    = {rem_q, quot_q[31]};
  assign trial_ge = trial >= {1'b0, div_mag};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    case (state_q)
      S_IDLE: begin
        if (is_div_op) begin
          op_d    = alu_control_i;
          a_d     = src_a_i;
          b_d     = src_b_i;
          rem_d   = 32'd0;
          quot_d  = a_mag_in;
          cnt_d   = 6'd32;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // trial < 2*divisor, so the difference always fits in 32 bits.
        rem_d  = trial_ge ? (trial[31:0] - div_mag) : trial[31:0];
        quot_d = {quot_q[30:0], trial_ge};
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quot_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
    end
  end

  // Sign fix-up. Quotient truncates toward zero and the remainder takes the
  // dividend's sign. Divide by zero bypasses the fix-up: all-ones quotient and
  // the raw dividend as remainder, for signed and unsigned ops alike.
  logic        b_zero;
  logic        neg_quot;
  logic        neg_rem;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_result;

  assign b_zero     = (b_q == 32'd0);
  assign neg_quot   = op_signed && (a_q[31] ^ b_q[31]);
  assign neg_rem    = op_signed && a_q[31];
  assign quot_fix   = b_zero ? 32'hFFFF_FFFF : (neg_quot ? -quot_q : quot_q);
  assign rem_fix    = b_zero ? a_q : (neg_rem ? -rem_q : rem_q);
  assign div_result = op_is_rem ? rem_fix : quot_fix;

  // ---------------------------------------------------------------------------
  // Outputs. Under reset the ALU behaves as an idle ALU with the stall gated
  // off, even if the state register still reads BUSY or DONE that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cpu_o = 1'b0;
    result_o    = comb_result;
    if (!rst_n_i) begin
      case (state_q)
        S_IDLE:  stall_cpu_o = is_div_op;
        S_BUSY: begin
          stall_cpu_o = 1'b1;
          result_o    = 32'd0;
        end
        S_DONE:  result_o = div_result;
        default: result_o = comb_result;
      endcase
    end
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- scoreboard bench for alu.
// The driver applies directed vectors and pushes the hand-computed response.
// The monitor pops on the negative edge: on a driver strobe for
// combinational/reset checks, and on the falling edge of stall_cpu_o for
// divider results, where it also checks the 33-cycle stall length.
// -----------------------------------------------------------------------------
module tb_alu;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  AND_ = 5'd2, OR_ = 5'd3;
  localparam logic [4:0] XOR_ = 5'd4, SLL = 5'd5,  SRL = 5'd6,  SRA = 5'd7;
  localparam logic [4:0] SLT = 5'd8,  SLTU = 5'd9, MUL = 5'd10, MULH = 5'd11;
  localparam logic [4:0] MULHSU = 5'd12, MULHU = 5'd13, DIV = 5'd14, DIVU = 5'd15;
  localparam logic [4:0] REM = 5'd16, REMU = 5'd17;

  logic        clk;
  logic        rst;
  logic [4:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] result;
  logic        zero;
  logic        stall;

  alu #(.ALU_CONTROL_WIDTH(5)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst),
    .alu_control_i(alu_control),
    .src_a_i      (src_a),
    .src_b_i      (src_b),
    .result_o     (result),
    .zero_o       (zero),
    .stall_cpu_o  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    bit          is_div;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   comb_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  task automatic push(input string nm, input logic [31:0] r, input bit is_div);
    exp_t e;
    e.name   = nm;
    e.res    = r;
    e.zero   = (r == 32'd0);
    e.is_div = is_div;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int stall_len  = 0;
  bit prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (comb_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL comb_pop: output presented with empty scoreboard");
      end else begin
        e = sb.pop_front();
        check({e.name, "_kind"}, {31'd0, e.is_div}, 32'd0);
        check(e.name, result, e.res);
        check({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
        check({e.name, "_stall"}, {31'd0, stall}, 32'd0);
      end
    end
    if (rst) begin
      stall_len  = 0;
      prev_stall = 1'b0;
    end else begin
      if (stall) begin
        stall_len++;
        if (stall_len >= 2) check("busy_result", result, 32'd0);
      end else if (prev_stall) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL div_pop: divide finished with empty scoreboard");
        end else begin
          e = sb.pop_front();
          check({e.name, "_kind"}, {31'd0, e.is_div}, 32'd1);
          check(e.name, result, e.res);
          check({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
          check({e.name, "_cycles"}, 32'(stall_len), 32'd33);
        end
        stall_len = 0;
      end
      prev_stall = stall;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_comb(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input string nm);
    @(posedge clk);
    #1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    push(nm, r, 1'b0);
    comb_valid  = 1'b1;
    @(negedge clk);
    #1;
    comb_valid  = 1'b0;
  endtask

  // Returns at the negative edge of the DONE cycle. With scramble set, the
  // inputs are overwritten with a non-divide op part-way through BUSY.
  task automatic wait_done(input bit scramble);
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall) seen = 1'b1;
      else if (seen) done = 1'b1;
      if (scramble && i == 5) begin
        #1;
        alu_control = ADD;
        src_a       = 32'hDEAD_BEEF;
        src_b       = 32'h0000_0003;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL div_timeout: stall_cpu_o did not complete within 40 cycles");
    end
  endtask

  task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input string nm, input bit scramble);
    @(posedge clk);
    #1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    push(nm, r, 1'b1);
    wait_done(scramble);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    alu_control = ADD;
    src_a       = 32'd2;
    src_b       = 32'd3;

    // Under reset: combinational ops still work, divide ops give 0, no stall.
    do_comb(ADD,  32'd2,    32'd3,  32'd5, "rst_add");
    do_comb(DIVU, 32'd5463, 32'd31, 32'd0, "rst_divu");

    // DIVU held across reset release.
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("divu_5463_31", 32'd176, 1'b1);
    wait_done(1'b0);

    // Combinational vectors.
    do_comb(SUB,    32'd5,         32'd5,         32'd0,         "sub_zero");
    do_comb(ADD,    32'hFFFF_FFFF, 32'd1,         32'd0,         "add_wrap");
    do_comb(SRA,    32'h8000_0000, 32'd4,         32'hF800_0000, "sra");
    do_comb(SRL,    32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
    do_comb(SLL,    32'd1,         32'h0000_0023, 32'd8,         "sll_shamt5");
    do_comb(AND_,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, "and");
    do_comb(OR_,    32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or");
    do_comb(XOR_,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor");
    do_comb(SLT,    32'hFFFF_FFFF, 32'd1,         32'd1,         "slt");
    do_comb(SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu");
    do_comb(MUL,    32'd7,         32'd6,         32'd42,        "mul");
    do_comb(MUL,    32'h0001_0000, 32'h0001_0000, 32'd0,         "mul_wrap");
    do_comb(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    do_comb(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         "mulh_m1");
    do_comb(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_comb(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    do_comb(MULHU,  32'h8000_0000, 32'd2,         32'd1,         "mulhu_2");
    do_comb(5'd20,  32'd9,         32'd9,         32'd0,         "unused_20");
    do_comb(5'd31,  32'hFFFF_FFFF, 32'd1,         32'd0,         "unused_31");

    // Divider vectors; the second one scrambles the inputs during BUSY.
    do_div(REMU, 32'd5463,      32'd31,        32'd7,         "remu_5463_31", 1'b0);
    do_div(DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2",     1'b1);
    do_div(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2",     1'b0);
    do_div(DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2",     1'b0);
    do_div(REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         "rem_7_m2",     1'b0);
    do_div(DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, "divu_by0",     1'b0);
    do_div(REMU, 32'd100,       32'd0,         32'd100,       "remu_by0",     1'b0);
    do_div(DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_m5_by0",   1'b0);
    do_div(REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_m5_by0",   1'b0);
    do_div(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",      1'b0);
    do_div(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf",      1'b0);

    // Back-to-back: the second op is applied in the IDLE cycle right after DONE.
    do_div(DIVU, 32'd100, 32'd7, 32'd14, "b2b_divu_100_7", 1'b0);
    do_div(DIVU, 32'd9,   32'd3, 32'd3,  "b2b_divu_9_3",   1'b0);

    // Reset in BUSY cycle 10 aborts; a fresh DIVU then completes normally.
    @(posedge clk);
    #1;
    alu_control = DIVU;
    src_a       = 32'd5463;
    src_b       = 32'd31;
    repeat (10) @(posedge clk);
    #1;
    rst        = 1'b1;
    push("rst_in_busy", 32'd0, 1'b0);
    comb_valid = 1'b1;
    @(negedge clk);
    #1;
    comb_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("divu_after_abort", 32'd176, 1'b1);
    wait_done(1'b0);

    do_comb(ADD, 32'd40, 32'd2, 32'd42, "add_after_div");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
